// File: rtl/cdb_broadcaster.sv
// Common data bus broadcaster: buffers one result per functional unit and
// drives one buffered result per cycle onto a registered bus, round-robin by tag.
module cdb_broadcaster #(
  parameter int NUM_FU = 8,
  parameter int TAG_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*DATA_W-1:0] fu_result,
  output logic [NUM_FU-1:0]        fu_ready,
  input  logic                     cdb_hold,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_value,
  output logic [15:0]              cdb_count
);

  localparam int PTR_W = (NUM_FU > 2) ? $clog2(NUM_FU) : 1;
  typedef logic [PTR_W-1:0] slot_t;
  localparam slot_t FIRST_SLOT = slot_t'(1);
  localparam slot_t LAST_SLOT  = slot_t'(NUM_FU - 1);

  logic [NUM_FU-1:0] pending;
  logic [NUM_FU-1:0] pending_next;
  logic [NUM_FU-1:0] capture;
  logic [DATA_W-1:0] result_buf [NUM_FU];
  slot_t             rr_ptr;
  slot_t             grant_idx;
  logic              grant_hit;
  logic              grant_fire;

  // Slot 0 is the "no producer" tag, so its result lane is never consumed.
  logic unused_slot0;
  assign unused_slot0 = ^fu_result[DATA_W-1:0];

  always_comb begin
    fu_ready    = ~pending;
    fu_ready[0] = 1'b0;
  end

  assign capture = fu_valid & fu_ready;

  // Scan NUM_FU-1 slots starting at rr_ptr, wrapping from the last slot back to 1.
  always_comb begin : rr_search
    int unsigned idx;
    slot_t       cand;
    grant_hit = 1'b0;
    grant_idx = FIRST_SLOT;
    idx       = 0;
    cand      = FIRST_SLOT;
    for (int unsigned k = 0; k < NUM_FU - 1; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - (NUM_FU - 1);
      cand = slot_t'(idx);
      if (!grant_hit && pending[cand]) begin
        grant_hit = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_fire = grant_hit & ~cdb_hold;

  always_comb begin
    pending_next = pending | capture;
    if (grant_fire) pending_next[grant_idx] = 1'b0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      pending   <= '0;
      rr_ptr    <= FIRST_SLOT;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_count <= '0;
      for (int unsigned i = 0; i < NUM_FU; i++) result_buf[i] <= '0;
    end else begin
      pending <= pending_next;
      for (int unsigned i = 1; i < NUM_FU; i++) begin
        if (capture[i]) result_buf[i] <= fu_result[i*DATA_W +: DATA_W];
      end
      if (!cdb_hold) begin
        if (grant_hit) begin
          cdb_valid <= 1'b1;
          cdb_tag   <= TAG_W'(grant_idx);
          cdb_value <= result_buf[grant_idx];
          rr_ptr    <= (grant_idx == LAST_SLOT) ? FIRST_SLOT : grant_idx + FIRST_SLOT;
          cdb_count <= cdb_count + 16'd1;
        end else begin
          cdb_valid <= 1'b0;
          cdb_tag   <= '0;
          cdb_value <= '0;
        end
      end
    end
  end

endmodule
